pingpong_frame_buf: RTL and testbench
=====================================

# pingpong_frame_buf

Parametrised double-buffered (ping-pong) frame store between the pixel source and the display scan-out path. A writer fills one bank at sequential addresses while a reader drains the other. Banks swap ownership automatically at frame boundaries, replacing the single-bank store with its fixed 24-bit RGB pixel and external addressing. Pixel width, channel count and frame depth are parameters. Flow control is explicit (valid/ready on write, request/valid on read), and frame boundaries are flagged on the read side.

## Interface
- DEPTH, 10000, pixels per frame (per bank); ≥ 2
- CH, 3, channels per pixel
- CW, 8, bits per channel
- PW, CH*CW, derived pixel width; not overridable
- AW, ceil(log2(DEPTH)), derived address width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; held low = reset
- wr_valid  in  1  writer presents a pixel
- wr_data  in  PW  pixel; channel k at bits [k*CW+CW-1 : k*CW], channel 0 = R, 1 = G, 2 = B
- wr_ready  out  1  write bank accepting
- rd_en  in  1  request next pixel from read bank
- rd_valid  out  1  rd_pix holds valid pixel
- rd_pix  out  PW  pixel, same channel packing as wr_data
- rd_sof  out  1  with rd_valid: pixel at address 0
- rd_eof  out  1  with rd_valid: pixel at address DEPTH-1
- rd_underrun  out  1  one-cycle pulse: rd_en with no readable bank
- frame_ready  out  1  read bank is FULL or DRAINING
- buf_full  out  2  bit b = bank b in FULL state
- buf_empty  out  2  bit b = bank b in EMPTY state
- wr_bank  out  1  bank owned by writer
- rd_bank  out  1  bank owned by reader

## Operation
- Per-bank state: EMPTY → FILLING → FULL → DRAINING → EMPTY.
- Writer:
  - wr_ready = writer bank in EMPTY or FILLING.
  - Accepted write (wr_valid & wr_ready): stores at wr_addr, wr_addr+1, bank EMPTY→FILLING.
  - Write at wr_addr = DEPTH-1: bank → FULL, wr_addr → 0, wr_bank toggles.
- Reader:
  - rd_en is accepted when the read bank is FULL or DRAINING. An accepted request reads rd_addr, increments rd_addr, and moves FULL→DRAINING.
  - Accepted read at rd_addr = DEPTH-1: bank → EMPTY, rd_addr → 0, rd_bank toggles.
  - rd_en when not accepted: no state change, rd_underrun pulses.
- Writer and reader never address the same bank in one cycle; state prevents it. There is no bypass path.
- Simultaneous write completion on one bank and read completion on the other: both transitions take effect in the same edge.
- No overwrite mode. A full store backpressures via wr_ready.
- Reset:
  - Both banks EMPTY; wr_bank = rd_bank = 0; addresses 0.
  - rd_valid, rd_sof, rd_eof, rd_underrun, rd_pix = 0; wr_ready = 1; buf_empty = 2'b11; buf_full = 0; frame_ready = 0.
  - RAM contents are not reset.
- Reset asserted mid-frame discards partial and full frames. No pixel output follows until a new frame is written.

## Timing
- Write: accepted on the edge where wr_valid & wr_ready; buf_full/wr_bank update on that same edge.
- Read latency is 1 cycle: a request accepted at edge N gives rd_valid, rd_pix, rd_sof and rd_eof at edge N+1, held for one cycle.
- Back-to-back rd_en gives one pixel per cycle.
- A bank freed by its last read gives wr_ready high from the following edge if the writer is waiting on it.
- frame_ready rises on the edge after the last write of a frame. Reading may start in that cycle.
- rd_underrun is registered and appears at edge N+1 for a failed request at edge N.
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs.

## Structure
- pingpong_pkg holds:
  - the bank state enum (EMPTY, FILLING, FULL, DRAINING);
  - channel index constants CH_R = 0, CH_G = 1, CH_B = 2;
  - a function extracting channel k from a packed pixel.
- Sub-module fb_bank_ram (params WIDTH, DEPTH): one write port and one registered read port.
  - Instantiated twice, or once with the bank bit as address MSB.
  - Synthesises to block RAM; no reset on the array.
- Top holds the two bank state registers, the address counters and the flag logic.

## Test plan
- Reset: drive reset low during a partial fill with DEPTH = 16 → all outputs at reset values next cycle. After release, the first 16 writes land in bank 0 from address 0.
- Fill: 16 writes with wr_data = index → after the 16th, buf_full = 2'b01, wr_bank = 1, frame_ready = 1, buf_empty = 2'b10.
- Drain: hold rd_en for 16 cycles → rd_pix = 0..15 on consecutive cycles, rd_sof with 0, rd_eof with 15. Bank 0 is EMPTY and rd_bank = 1 after the last edge.
- Backpressure: 32 writes fill both banks → wr_ready = 0 on the 33rd. Drain bank 0 → wr_ready = 1 the cycle after the last read, and the next write goes to bank 0 address 0.
- Concurrency and underrun:
  - Drain bank 0 while writing bank 1 on the same cycles → no data corruption in either bank.
  - rd_en after reset with no frame → rd_underrun single pulse, rd_valid = 0.
- Parameters: CH = 4, CW = 4, DEPTH = 5, pixel 16'hA5C3 → rd_pix = 16'hA5C3, channel 0 = 4'h3, channel 3 = 4'hA. Depth wrap occurs after 5 writes.

Source files
------------

// File: rtl/pingpong_pkg.sv
// -----------------------------------------------------------------------------
// pingpong_pkg
// Shared definitions for the ping-pong frame buffer:
//   - bank_state_e : per-bank ownership state (EMPTY -> FILLING -> FULL -> DRAINING)
//   - CH_R/CH_G/CH_B : channel indices within a packed pixel
//   - get_channel  : extract channel k (width cw) from a packed pixel
// No ports (package).
// -----------------------------------------------------------------------------
package pingpong_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // Widest pixel the helper can unpack; callers zero-extend into this.
  localparam int MAX_PW = 256;

  // Channel k occupies bits [k*cw+cw-1 : k*cw]; channels up to 32 bits wide.
  function automatic logic [31:0] get_channel(input logic [MAX_PW-1:0] pix,
                                              input int k,
                                              input int cw);
    logic [MAX_PW-1:0] w_shifted;
    logic [31:0]       w_mask;
    w_shifted = pix >> (k * cw);
    w_mask    = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    return w_shifted[31:0] & w_mask;
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// -----------------------------------------------------------------------------
// fb_bank_ram
// One bank of frame storage: simple dual-port RAM with a synchronous write
// port and a registered read port. The array is never reset so it maps onto
// block RAM.
// Ports:
//   clk        : clock, rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read strobe; o_rd_data updates on the next edge
//   i_rd_addr  : read address
//   o_rd_data  : registered read data (holds when i_rd_en is low)
// -----------------------------------------------------------------------------
module fb_bank_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pingpong_frame_buf.sv
// -----------------------------------------------------------------------------
// pingpong_frame_buf
// Double-buffered frame store. The writer fills one bank at sequential
// addresses while the reader drains the other; banks hand over automatically
// when a frame is completely written / completely read.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low reset
//   wr_valid    : writer presents wr_data
//   wr_data     : pixel, channel k at [k*CW+CW-1 : k*CW]
//   wr_ready    : writer bank is EMPTY or FILLING
//   rd_en       : request the next pixel
//   rd_valid    : rd_pix valid (one cycle after an accepted rd_en)
//   rd_pix      : pixel read, zero when rd_valid is low
//   rd_sof      : with rd_valid, pixel came from address 0
//   rd_eof      : with rd_valid, pixel came from address DEPTH-1
//   rd_underrun : one-cycle pulse after an rd_en with no readable bank
//   frame_ready : read bank is FULL or DRAINING
//   buf_full    : bit b = bank b FULL
//   buf_empty   : bit b = bank b EMPTY
//   wr_bank     : bank owned by the writer
//   rd_bank     : bank owned by the reader
// -----------------------------------------------------------------------------
module pingpong_frame_buf
  import pingpong_pkg::*;
#(
  parameter  int DEPTH = 10000,
  parameter  int CH    = 3,
  parameter  int CW    = 8,
  localparam int PW    = CH * CW,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [PW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [PW-1:0] rd_pix,
  output logic          rd_sof,
  output logic          rd_eof,
  output logic          rd_underrun,
  output logic          frame_ready,
  output logic [1:0]    buf_full,
  output logic [1:0]    buf_empty,
  output logic          wr_bank,
  output logic          rd_bank
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  bank_state_e   r_state      [2];
  bank_state_e   w_state_next [2];
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic          r_rd_sel;      // bank that produced the pixel now on rd_pix
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_rd_addr;
  logic          r_rd_valid;
  logic          r_rd_sof;
  logic          r_rd_eof;
  logic          r_rd_underrun;
  logic [PW-1:0] w_ram_q      [2];

  logic w_wr_ok;
  logic w_rd_ok;
  logic w_wr_fire;
  logic w_rd_fire;
  logic w_wr_last;
  logic w_rd_last;

  // Ownership is decided purely by bank state: a bank in EMPTY/FILLING can
  // only be touched by the writer, FULL/DRAINING only by the reader. Even when
  // wr_bank == rd_bank the two ports can therefore never fire on one bank.
  assign w_wr_ok   = (r_state[r_wr_bank] == EMPTY) || (r_state[r_wr_bank] == FILLING);
  assign w_rd_ok   = (r_state[r_rd_bank] == FULL)  || (r_state[r_rd_bank] == DRAINING);
  assign w_wr_fire = wr_valid && w_wr_ok;
  assign w_rd_fire = rd_en && w_rd_ok;
  assign w_wr_last = (r_wr_addr == LAST_ADDR);
  assign w_rd_last = (r_rd_addr == LAST_ADDR);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic w_wr_here;
      logic w_rd_here;

      assign w_wr_here = w_wr_fire && (r_wr_bank == 1'(gi));
      assign w_rd_here = w_rd_fire && (r_rd_bank == 1'(gi));

      assign w_state_next[gi] = w_wr_here ? (w_wr_last ? FULL  : FILLING)  :
                                w_rd_here ? (w_rd_last ? EMPTY : DRAINING) :
                                r_state[gi];

      assign buf_full[gi]  = (r_state[gi] == FULL);
      assign buf_empty[gi] = (r_state[gi] == EMPTY);

      fb_bank_ram #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
      ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_here),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_here),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_ram_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state[0]    <= EMPTY;
      r_state[1]    <= EMPTY;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_sof      <= 1'b0;
      r_rd_eof      <= 1'b0;
      r_rd_underrun <= 1'b0;
    end else begin
      r_state[0] <= w_state_next[0];
      r_state[1] <= w_state_next[1];

      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_addr <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_addr <= r_wr_addr + AW'(1);
        end
      end

      if (w_rd_fire) begin
        r_rd_sel <= r_rd_bank;
        if (w_rd_last) begin
          r_rd_addr <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_addr <= r_rd_addr + AW'(1);
        end
      end

      r_rd_valid    <= w_rd_fire;
      r_rd_sof      <= w_rd_fire && (r_rd_addr == '0);
      r_rd_eof      <= w_rd_fire && w_rd_last;
      r_rd_underrun <= rd_en && !w_rd_ok;
    end
  end

  // The RAM output register has no reset, so the pixel is masked by the
  // (reset) valid flag; this keeps rd_pix at zero after reset.
  assign rd_pix      = r_rd_valid ? w_ram_q[r_rd_sel] : '0;
  assign rd_valid    = r_rd_valid;
  assign rd_sof      = r_rd_sof;
  assign rd_eof      = r_rd_eof;
  assign rd_underrun = r_rd_underrun;
  assign wr_ready    = w_wr_ok;
  assign frame_ready = w_rd_ok;
  assign wr_bank     = r_wr_bank;
  assign rd_bank     = r_rd_bank;

endmodule

// File: tb/tb_pingpong_frame_buf.sv
// -----------------------------------------------------------------------------
// tb_pingpong_frame_buf
// Two instances: DEPTH=16 RGB888 (frame-level reference model, directed and
// random traffic) and DEPTH=5 4x4-bit (table of per-cycle vectors).
// -----------------------------------------------------------------------------
module tb_pingpong_frame_buf;

  localparam int D16 = 16;
  localparam int D5  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_failed = 0;

  // ---------------- DEPTH=16, CH=3, CW=8 ----------------
  logic        rst16_n;
  logic        t16_wr_valid;
  logic [23:0] t16_wr_data;
  logic        t16_wr_ready;
  logic        t16_rd_en;
  logic        t16_rd_valid;
  logic [23:0] t16_rd_pix;
  logic        t16_rd_sof;
  logic        t16_rd_eof;
  logic        t16_rd_underrun;
  logic        t16_frame_ready;
  logic [1:0]  t16_buf_full;
  logic [1:0]  t16_buf_empty;
  logic        t16_wr_bank;
  logic        t16_rd_bank;

  pingpong_frame_buf #(.DEPTH(D16), .CH(3), .CW(8)) u_dut16 (
    .clk         (clk),
    .reset       (rst16_n),
    .wr_valid    (t16_wr_valid),
    .wr_data     (t16_wr_data),
    .wr_ready    (t16_wr_ready),
    .rd_en       (t16_rd_en),
    .rd_valid    (t16_rd_valid),
    .rd_pix      (t16_rd_pix),
    .rd_sof      (t16_rd_sof),
    .rd_eof      (t16_rd_eof),
    .rd_underrun (t16_rd_underrun),
    .frame_ready (t16_frame_ready),
    .buf_full    (t16_buf_full),
    .buf_empty   (t16_buf_empty),
    .wr_bank     (t16_wr_bank),
    .rd_bank     (t16_rd_bank)
  );

  // ---------------- DEPTH=5, CH=4, CW=4 ----------------
  logic        rst5_n;
  logic        t5_wr_valid;
  logic [15:0] t5_wr_data;
  logic        t5_wr_ready;
  logic        t5_rd_en;
  logic        t5_rd_valid;
  logic [15:0] t5_rd_pix;
  logic        t5_rd_sof;
  logic        t5_rd_eof;
  logic        t5_rd_underrun;
  logic        t5_frame_ready;
  logic [1:0]  t5_buf_full;
  logic [1:0]  t5_buf_empty;
  logic        t5_wr_bank;
  logic        t5_rd_bank;

  pingpong_frame_buf #(.DEPTH(D5), .CH(4), .CW(4)) u_dut5 (
    .clk         (clk),
    .reset       (rst5_n),
    .wr_valid    (t5_wr_valid),
    .wr_data     (t5_wr_data),
    .wr_ready    (t5_wr_ready),
    .rd_en       (t5_rd_en),
    .rd_valid    (t5_rd_valid),
    .rd_pix      (t5_rd_pix),
    .rd_sof      (t5_rd_sof),
    .rd_eof      (t5_rd_eof),
    .rd_underrun (t5_rd_underrun),
    .frame_ready (t5_frame_ready),
    .buf_full    (t5_buf_full),
    .buf_empty   (t5_buf_empty),
    .wr_bank     (t5_wr_bank),
    .rd_bank     (t5_rd_bank)
  );

  // ---------------- generic comparison ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- frame-level reference model (DEPTH=16) ----------------
  // The store is treated as a stream of pixels: m_wr pixels accepted, m_rd
  // pixels delivered. Whole frames written = m_wr/D16, whole frames read =
  // m_rd/D16. At most two written-but-unread frames may exist.
  int          m_wr;
  int          m_rd;
  logic [23:0] m_q[$];
  logic        e_rv, e_sof, e_eof, e_unr;
  logic [23:0] e_pix;
  bit          quiet;

  task automatic model_reset();
    m_wr = 0;
    m_rd = 0;
    m_q.delete();
    e_rv = 0; e_sof = 0; e_eof = 0; e_unr = 0; e_pix = '0;
  endtask

  task automatic check16(input string tag);
    int         comp, fr;
    logic [1:0] ef, ee;
    logic [11:0] exp_v, got_v;
    comp = m_wr / D16;
    fr   = m_rd / D16;
    ef = 2'b00;
    ee = 2'b11;
    // Written-but-unread frames sit in bank (frame % 2); the oldest is
    // DRAINING once any of its pixels has been read, otherwise FULL.
    for (int f = fr; f < comp; f++) begin
      ee[f % 2] = 1'b0;
      if (!(f == fr && (m_rd % D16) != 0)) ef[f % 2] = 1'b1;
    end
    if ((m_wr % D16) != 0) ee[comp % 2] = 1'b0;
    exp_v = {((comp - fr) < 2), e_rv, e_sof, e_eof, e_unr, (comp > fr),
             ef, ee, 1'(comp % 2), 1'(fr % 2)};
    got_v = {t16_wr_ready, t16_rd_valid, t16_rd_sof, t16_rd_eof, t16_rd_underrun,
             t16_frame_ready, t16_buf_full, t16_buf_empty, t16_wr_bank, t16_rd_bank};
    chk($sformatf("%s_status", tag), 64'(got_v), 64'(exp_v));
    if (e_rv) chk($sformatf("%s_pix", tag), 64'(t16_rd_pix), 64'(e_pix));
  endtask

  task automatic step16(input logic wv, input logic [23:0] wd, input logic re, input string tag);
    int   comp, fr;
    logic wok, rok;
    comp = m_wr / D16;
    fr   = m_rd / D16;
    wok  = (comp - fr) < 2;
    rok  = m_rd < comp * D16;
    t16_wr_valid = wv;
    t16_wr_data  = wd;
    t16_rd_en    = re;
    e_rv  = re && rok;
    e_unr = re && !rok;
    e_sof = 1'b0;
    e_eof = 1'b0;
    if (re && rok) begin
      e_pix = m_q.pop_front();
      e_sof = (m_rd % D16) == 0;
      e_eof = (m_rd % D16) == D16 - 1;
      m_rd++;
    end
    if (wv && wok) begin
      m_q.push_back(wd);
      m_wr++;
    end
    @(posedge clk); #1;
    if (!quiet)
      $display("[TB] %s wv=%0b wd=%06h re=%0b -> rv=%0b pix=%06h sof=%0b eof=%0b unr=%0b wrdy=%0b",
               tag, wv, wd, re, t16_rd_valid, t16_rd_pix, t16_rd_sof, t16_rd_eof,
               t16_rd_underrun, t16_wr_ready);
    check16(tag);
  endtask

  task automatic reset16(input string tag);
    t16_wr_valid = 1'b0;
    t16_rd_en    = 1'b0;
    rst16_n      = 1'b0;
    model_reset();
    #2;
    check16({tag, "_async"});
    chk({tag, "_pix0"}, 64'(t16_rd_pix), 64'h0);
    @(posedge clk); #1;
    check16({tag, "_hold"});
    rst16_n = 1'b1;
  endtask

  // ---------------- vector table (DEPTH=5, CH=4, CW=4) ----------------
  typedef struct {
    logic        wv;
    logic [15:0] wd;
    logic        re;
    logic        e_rv;
    logic [15:0] e_pix;
    logic        e_sof;
    logic        e_eof;
    logic        e_unr;
    logic        e_fr;
    logic [1:0]  e_full;
    logic [1:0]  e_empty;
    logic        e_wb;
    logic        e_rb;
    logic        e_wrdy;
  } vec5_t;

  vec5_t tab[13];

  initial begin
    // inputs                      | expected after the edge
    //          wv  wd      re      rv  pix     sof eof unr fr  full   empty  wb  rb  wrdy
    tab[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1};
    tab[1]  = '{1'b1, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1};
    tab[2]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1};
    tab[3]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1};
    tab[4]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1};
    tab[5]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1};
    tab[6]  = '{1'b1, 16'h1111, 1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    tab[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    tab[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    tab[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    tab[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1};
    tab[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1};
    tab[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] got5, exp5;
    quiet        = 1'b0;
    rst16_n      = 1'b0;
    rst5_n       = 1'b0;
    t16_wr_valid = 1'b0;
    t16_wr_data  = '0;
    t16_rd_en    = 1'b0;
    t5_wr_valid  = 1'b0;
    t5_wr_data   = '0;
    t5_rd_en     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check16("reset");
    chk("reset_pix", 64'(t16_rd_pix), 64'h0);
    chk("reset5_status", 64'({t5_wr_ready, t5_buf_empty, t5_buf_full, t5_frame_ready, t5_rd_valid}),
        64'({1'b1, 2'b11, 2'b00, 1'b0, 1'b0}));
    rst16_n = 1'b1;
    rst5_n  = 1'b1;

    // ---- DEPTH=5 table ----
    for (int i = 0; i < 13; i++) begin
      t5_wr_valid = tab[i].wv;
      t5_wr_data  = tab[i].wd;
      t5_rd_en    = tab[i].re;
      @(posedge clk); #1;
      $display("[TB] d5 vec%0d wv=%0b wd=%04h re=%0b -> rv=%0b pix=%04h sof=%0b eof=%0b unr=%0b",
               i, tab[i].wv, tab[i].wd, tab[i].re, t5_rd_valid, t5_rd_pix, t5_rd_sof, t5_rd_eof,
               t5_rd_underrun);
      got5 = {t5_rd_valid, t5_rd_sof, t5_rd_eof, t5_rd_underrun, t5_frame_ready,
              t5_buf_full, t5_buf_empty, t5_wr_ready};
      exp5 = {tab[i].e_rv, tab[i].e_sof, tab[i].e_eof, tab[i].e_unr, tab[i].e_fr,
              tab[i].e_full, tab[i].e_empty, tab[i].e_wrdy};
      chk($sformatf("d5_vec%0d_flags", i), 64'(got5), 64'(exp5));
      chk($sformatf("d5_vec%0d_banks", i), 64'({t5_wr_bank, t5_rd_bank}),
          64'({tab[i].e_wb, tab[i].e_rb}));
      if (tab[i].e_rv) chk($sformatf("d5_vec%0d_pix", i), 64'(t5_rd_pix), 64'(tab[i].e_pix));
      if (i == 6) begin
        chk("d5_ch0", 64'(pingpong_pkg::get_channel(256'(t5_rd_pix), 0, 4)), 64'h3);
        chk("d5_ch3", 64'(pingpong_pkg::get_channel(256'(t5_rd_pix), 3, 4)), 64'hA);
      end
    end
    t5_wr_valid = 1'b0;
    t5_rd_en    = 1'b0;

    // ---- DEPTH=16: underrun with no frame, single pulse ----
    step16(1'b0, 24'h0, 1'b1, "unr");
    chk("unr_pulse", 64'(t16_rd_underrun), 64'h1);
    step16(1'b0, 24'h0, 1'b0, "unr_idle");
    chk("unr_gone", 64'(t16_rd_underrun), 64'h0);

    // ---- partial fill then asynchronous reset ----
    for (int i = 0; i < 7; i++) step16(1'b1, 24'(24'hEE0000 + i), 1'b0, "partial");
    reset16("midrst");

    // ---- fill bank 0 with index values ----
    for (int i = 0; i < D16; i++) step16(1'b1, 24'(i), 1'b0, $sformatf("fill%0d", i));
    chk("fill_buf_full",  64'(t16_buf_full),    64'h1);
    chk("fill_buf_empty", 64'(t16_buf_empty),   64'h2);
    chk("fill_wr_bank",   64'(t16_wr_bank),     64'h1);
    chk("fill_frame_rdy", 64'(t16_frame_ready), 64'h1);

    // ---- drain bank 0 ----
    for (int i = 0; i < D16; i++) step16(1'b0, 24'h0, 1'b1, $sformatf("drain%0d", i));
    chk("drain_rd_bank", 64'(t16_rd_bank),      64'h1);
    chk("drain_empty0",  64'(t16_buf_empty[0]), 64'h1);

    // ---- backpressure: fill both banks, drain bank 0 while writer waits ----
    reset16("bprst");
    for (int i = 0; i < 2 * D16; i++) step16(1'b1, 24'(24'h200000 + i), 1'b0, "bp_fill");
    chk("bp_wr_ready_low", 64'(t16_wr_ready), 64'h0);
    step16(1'b1, 24'h300000, 1'b0, "bp_33rd");
    chk("bp_still_low", 64'(t16_wr_ready), 64'h0);
    for (int i = 0; i < D16; i++) step16(1'b1, 24'h300000, 1'b1, "bp_drain0");
    chk("bp_ready_after", 64'(t16_wr_ready), 64'h1);
    // drain bank 1 while refilling bank 0 on the same cycles
    for (int i = 0; i < D16; i++) step16(1'b1, 24'(24'h300000 + i), 1'b1, "conc");
    for (int i = 0; i < 2 * D16; i++) step16(1'b0, 24'h0, 1'b1, "conc_drain");

    // ---- randomized traffic against the model ----
    quiet = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step16(1'($urandom_range(0, 3) != 0), 24'($urandom), 1'($urandom_range(0, 1)), "rand");
    end
    quiet = 1'b0;
    t16_wr_valid = 1'b0;
    t16_rd_en    = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
